// File: rtl/aes_selftest_seq_pkg.sv
// aes_seq_pkg: shared constants, state encoding and the Nr lookup for the AES self-test sequencer.
// No ports. Holds the key-size mode encodings, the round counts, the FSM state enum and nr_of().
package aes_seq_pkg;
  localparam logic [1:0] MODE_128 = 2'd0;
  localparam logic [1:0] MODE_192 = 2'd1;
  localparam logic [1:0] MODE_256 = 2'd2;
  localparam logic [1:0] MODE_RSV = 2'd3;
  localparam int WD_W = 8;
  localparam logic [WD_W-1:0] NR_128 = 8'd10;
  localparam logic [WD_W-1:0] NR_192 = 8'd12;
  localparam logic [WD_W-1:0] NR_256 = 8'd14;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ENC_REQ,
    S_ENC_WAIT,
    S_DEC_REQ,
    S_DEC_WAIT,
    S_CHECK,
    S_FIN
  } state_t;
  function automatic logic [WD_W-1:0] nr_of(input logic [1:0] m);
    return (m == MODE_256) ? NR_256 : (m == MODE_192) ? NR_192 : NR_128;
  endfunction
endpackage

// File: rtl/aes_selftest_seq_if.sv
// aes_selftest_seq_if: handshake bundle between the sequencer and the encrypt/decrypt cores.
// Signals: enc_start/enc_in -> encrypt core, enc_done/enc_out <- encrypt core;
//          dec_start/dec_in -> decrypt core, dec_done/dec_out <- decrypt core.
// Modports: master (sequencer side), slave (core side).
interface aes_selftest_seq_if;
  logic         enc_start;
  logic [127:0] enc_in;
  logic         enc_done;
  logic [127:0] enc_out;
  logic         dec_start;
  logic [127:0] dec_in;
  logic         dec_done;
  logic [127:0] dec_out;
  modport master (
    output enc_start, enc_in, dec_start, dec_in,
    input  enc_done, enc_out, dec_done, dec_out
  );
  modport slave (
    input  enc_start, enc_in, dec_start, dec_in,
    output enc_done, enc_out, dec_done, dec_out
  );
endinterface

// File: rtl/aes_selftest_seq_watchdog.sv
// aes_seq_watchdog: loadable down-counter with an expiry flag, shared by the encrypt and decrypt waits.
// Ports: i_clk, i_rst_n (sync, active-low); i_load/i_load_val reload the count;
//        i_en counts down; o_expire is high in the enabled cycle whose edge takes the count to zero.
module aes_seq_watchdog
  import aes_seq_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic            i_en,
  input  logic [WD_W-1:0] i_load_val,
  output logic            o_expire
);
  logic [WD_W-1:0] r_cnt;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_en && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end
  assign o_expire = i_en && (r_cnt == WD_W'(1));
endmodule

// File: rtl/aes_selftest_seq.sv
// aes_selftest_seq: AES encrypt/decrypt round-trip self-test sequencer over NUM_VEC vectors.
// Ports: i_clk, i_rst_n (sync, active-low); i_start/i_mode run request and key size;
//        i_vec_pt plaintext ROM data for o_vec_idx (plus i_vec_ct expected ciphertext when
//        KAT_CHECK_EN is defined); core = encrypt/decrypt handshake (master side);
//        o_key_mode latched key size; o_busy/o_done run status; o_pass/o_timeout sticky result;
//        o_fail_cnt saturating mismatch count; o_disp_byte low byte of the latest stage data.
// Build option: define KAT_CHECK_EN to add i_vec_ct and a known-answer ciphertext check.
module aes_selftest_seq
  import aes_seq_pkg::*;
#(
  parameter int NUM_VEC   = 4,
  parameter int SLACK_CYC = 4,
  parameter int IDX_W     = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic [127:0]     i_vec_pt,
`ifdef KAT_CHECK_EN
  input  logic [127:0]     i_vec_ct,
`endif
  output logic [IDX_W-1:0] o_vec_idx,
  output logic [1:0]       o_key_mode,
  aes_selftest_seq_if.master core,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic             o_timeout,
  output logic [IDX_W-1:0] o_fail_cnt,
  output logic [7:0]       o_disp_byte
);
  state_t           r_state, w_next;
  logic [IDX_W-1:0] r_vec_idx, r_fail_cnt;
  logic [1:0]       r_key_mode;
  logic [127:0]     r_enc_in, r_ct, r_pt;
  logic [7:0]       r_disp;
  logic             r_pass, r_timeout, r_rsv_done, r_bad;
  logic             w_expire, w_last, w_pass, w_fail;
  assign w_last = r_vec_idx == IDX_W'(NUM_VEC - 1);
  assign w_pass = (r_fail_cnt == '0) && !r_timeout;
  // r_bad carries a ciphertext mismatch into CHECK so a vector is counted at most once
  assign w_fail = r_bad || (r_pt != i_vec_pt);
  aes_seq_watchdog u_wd (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (r_state == S_ENC_REQ || r_state == S_DEC_REQ),
    .i_en      (r_state == S_ENC_WAIT || r_state == S_DEC_WAIT),
    .i_load_val(nr_of(r_key_mode) + WD_W'(SLACK_CYC)),
    .o_expire  (w_expire)
  );
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // A done arriving together with watchdog expiry is taken as done
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     w_next = (i_start && i_mode != MODE_RSV) ? S_ENC_REQ : S_IDLE;
      S_ENC_REQ:  w_next = S_ENC_WAIT;
      S_ENC_WAIT: w_next = core.enc_done ? S_DEC_REQ : w_expire ? S_FIN : S_ENC_WAIT;
      S_DEC_REQ:  w_next = S_DEC_WAIT;
      S_DEC_WAIT: w_next = core.dec_done ? S_CHECK : w_expire ? S_FIN : S_DEC_WAIT;
      S_CHECK:    w_next = w_last ? S_FIN : S_ENC_REQ;
      S_FIN:      w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    core.enc_start = r_state == S_ENC_REQ;
    core.enc_in    = (r_state == S_ENC_REQ) ? i_vec_pt : r_enc_in;
    core.dec_start = r_state == S_DEC_REQ;
    core.dec_in    = r_ct;
    o_busy         = r_state != S_IDLE;
    o_done         = (r_state == S_FIN) || r_rsv_done;
    o_pass         = (r_state == S_FIN) ? w_pass : r_pass;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vec_idx  <= '0;
      r_fail_cnt <= '0;
      r_key_mode <= MODE_128;
      r_enc_in   <= '0;
      r_ct       <= '0;
      r_pt       <= '0;
      r_disp     <= '0;
      r_pass     <= 1'b0;
      r_timeout  <= 1'b0;
      r_rsv_done <= 1'b0;
      r_bad      <= 1'b0;
    end else begin
      r_rsv_done <= (r_state == S_IDLE) && i_start && (i_mode == MODE_RSV);
      case (r_state)
        S_IDLE: if (i_start) begin
          r_pass    <= 1'b0;
          r_timeout <= 1'b0;
          if (i_mode != MODE_RSV) begin
            r_key_mode <= i_mode;
            r_vec_idx  <= '0;
            r_fail_cnt <= '0;
          end
        end
        S_ENC_REQ: begin
          r_enc_in <= i_vec_pt;
          r_disp   <= i_vec_pt[7:0];
          r_bad    <= 1'b0;
        end
        S_ENC_WAIT: if (core.enc_done) begin
          r_ct   <= core.enc_out;
          r_disp <= core.enc_out[7:0];
`ifdef KAT_CHECK_EN
          r_bad  <= core.enc_out != i_vec_ct;
`endif
        end else if (w_expire) r_timeout <= 1'b1;
        S_DEC_WAIT: if (core.dec_done) begin
          r_pt   <= core.dec_out;
          r_disp <= core.dec_out[7:0];
        end else if (w_expire) r_timeout <= 1'b1;
        S_CHECK: begin
          if (w_fail && !(&r_fail_cnt)) r_fail_cnt <= r_fail_cnt + 1'b1;
          if (!w_last) r_vec_idx <= r_vec_idx + 1'b1;
        end
        S_FIN: r_pass <= w_pass;
        default: ;
      endcase
    end
  end
  assign o_vec_idx   = r_vec_idx;
  assign o_key_mode  = r_key_mode;
  assign o_timeout   = r_timeout;
  assign o_fail_cnt  = r_fail_cnt;
  assign o_disp_byte = r_disp;
endmodule

// File: doc/aes_selftest_seq.md
Name: aes_selftest_seq

Overview:
- Parametrised AES round-trip self-test sequencer, replacing the fixed single-vector demo flow.
- For a selected key size, walks NUM_VEC plaintext vectors through an external iterative encrypt core, then a decrypt core.
- Checks each decrypted result against the original plaintext, counts failures, and exposes pass/fail status and a display byte for the 7-segment encoder/decoder path.
- Sits between the board-level top and the Encrypt/Decrypt/keyExpansion instances.

Parameters:
- NUM_VEC, 4, number of vectors per run (1..256).
- SLACK_CYC, 4, extra cycles allowed beyond Nr before a core is declared hung.
- IDX_W, 8, width of vec_idx and fail_cnt.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle run request; ignored while busy.
- mode  in  2  key size: 0=128, 1=192, 2=256, 3=reserved.
- vec_pt  in  128  plaintext for vec_idx (combinational ROM, valid same cycle).
- vec_idx  out  IDX_W  current vector index.
- key_mode  out  2  mode latched at start; drives key/expansion mux.
- enc_start  out  1  one-cycle pulse; enc_in is valid with it.
- enc_in  out  128  plaintext to encrypt core.
- enc_done  in  1  encrypt result valid (single cycle).
- enc_out  in  128  ciphertext.
- dec_start  out  1  one-cycle pulse; dec_in is valid with it.
- dec_in  out  128  ciphertext to decrypt core.
- dec_done  in  1  decrypt result valid.
- dec_out  in  128  recovered plaintext.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at run end.
- pass  out  1  sticky; 1 when the last run had fail_cnt==0 and no timeout.
- timeout  out  1  sticky; a core missed its deadline in the last run.
- fail_cnt  out  IDX_W  mismatching vectors in the last run; saturates at all-ones.
- disp_byte  out  8  low byte of the last stage data (pt, then ct, then recovered pt).

Behaviour:
- Reset (rst_n=0 at posedge clk): state IDLE; all outputs 0. The reset wins over any in-flight operation; late done pulses after reset are ignored.
- States: IDLE, ENC_REQ, ENC_WAIT, DEC_REQ, DEC_WAIT, CHECK, FIN.
- IDLE:
  - start=1 and mode!=3: latch key_mode, clear vec_idx/fail_cnt/pass/timeout, then go to ENC_REQ.
  - start=1 and mode==3: pulse done with pass=0 and timeout=0; stay in IDLE.
- ENC_REQ: enc_in=vec_pt, enc_start=1 for one cycle, load watchdog with Nr+SLACK_CYC (Nr=10/12/14 from key_mode), then go to ENC_WAIT.
- ENC_WAIT:
  - Watchdog decrements each cycle.
  - enc_done=1: latch enc_out into the ct register and dec_in, then go to DEC_REQ.
  - Watchdog reaches 0 without enc_done: set timeout, then go to FIN.
  - enc_done and watchdog expiry in the same cycle: done wins.
- DEC_REQ and DEC_WAIT: symmetric to the encrypt states, using dec_start/dec_done. Latch dec_out, then go to CHECK.
- CHECK (1 cycle):
  - Compare recovered pt with vec_pt[vec_idx]; on mismatch, increment fail_cnt (saturating).
  - If vec_idx==NUM_VEC-1, go to FIN; otherwise increment vec_idx and go to ENC_REQ.
- FIN: done=1 for one cycle; pass=(fail_cnt==0 && !timeout); go to IDLE. vec_idx holds its last value.
- start while busy is ignored, with no queuing.
- mode changes mid-run are ignored because key_mode is latched.
- A done pulse arriving outside its wait state is ignored.
- Latency per vector is enc latency + dec latency + 3 cycles (two REQ states plus CHECK). A run ends with one extra FIN cycle.

Optional Feature:
- Macro KAT_CHECK_EN.
- Defined:
  - Adds input port vec_ct[127:0], the expected ciphertext for vec_idx.
  - In ENC_WAIT, if enc_out!=vec_ct on enc_done, fail_cnt increments for that vector.
  - A vector is counted at most once even if both checks fail.
- Undefined: no vec_ct port; only the round-trip check applies.

Decomposition:
- Package aes_seq_pkg holds:
  - mode encodings (MODE_128/192/256/RSV);
  - the Nr constants 10/12/14;
  - the state enum;
  - the Nr-lookup function.
- One sub-module, aes_seq_watchdog: a loadable down-counter with an expiry flag, reused for both the encrypt and decrypt waits.

Test Plan:
- mode=0, vec_pt=00112233445566778899aabbccddeeff, model cores with 10-cycle latency that echo correctly -> one done pulse, pass=1, fail_cnt=0. With KAT_CHECK_EN and vec_ct=69c4e0d86a7b0430d8cdb78070b4c55a, still pass=1.
- mode=1 and mode=2, NUM_VEC=4, latencies 12 and 14, expected ct dda97ca4864cdfe06eaf70a0ec0d7191 and 8ea2b7ca516745bfeafc49904b496089 -> pass=1, vec_idx=3 at done.
- Decrypt model corrupts vector 2 (bit 0 flipped) -> fail_cnt=1, pass=0, other vectors unaffected.
- Encrypt model never asserts enc_done in mode=0 -> timeout=1 exactly 14 cycles after enc_start, done pulse, pass=0.
- rst_n=0 during DEC_WAIT, then a late dec_done -> all outputs 0, state IDLE, late done ignored. A fresh start then completes normally.
- mode=3 start -> immediate done, pass=0. start pulsed during busy -> no effect on vec_idx or sequencing.
